// File: rtl/schroeder_filter.sv
// Schroeder reverb section: comb (MODE=0) or all-pass (MODE=1) on a circular delay line.
// Define FILTER_SATURATE_EN to clamp sums instead of wrapping them.
module schroeder_filter #(
    parameter int WIDTH    = 24,
    parameter int FRAC     = 8,
    parameter int MAXDELAY = 4096,
    parameter int MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [WIDTH+FRAC-1:0]   in,
    input  logic [WIDTH+FRAC-1:0]   tau,
    input  logic [WIDTH+FRAC-1:0]   gain,
    output logic [WIDTH+FRAC-1:0]   out
);

    localparam int WORD = WIDTH + FRAC;
    localparam int AW   = $clog2(MAXDELAY);
    localparam int SW   = WORD + 2;
    localparam int PW   = 2 * WORD;

    localparam logic signed [WIDTH-1:0] TZERO = '0;
    localparam logic signed [WIDTH-1:0] TMAX  = WIDTH'(MAXDELAY);
    localparam logic [AW:0]             FULL  = (AW+1)'(MAXDELAY);
    localparam logic signed [SW-1:0]    ONE   = SW'(1) <<< FRAC;

    function automatic logic signed [WORD-1:0] reduce(input logic signed [SW-1:0] s);
`ifdef FILTER_SATURATE_EN
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = SW'({1'b0, {(WORD-1){1'b1}}});
        lo = ~hi;
        if (s > hi)
            return hi[WORD-1:0];
        else if (s < lo)
            return lo[WORD-1:0];
        else
            return s[WORD-1:0];
`else
        return s[WORD-1:0];
`endif
    endfunction

    logic signed [WORD-1:0] mem [MAXDELAY];

    logic [AW-1:0]          wp;
    logic [AW:0]            fill;
    logic [AW-1:0]          d;
    logic [AW-1:0]          ra;
    logic signed [WIDTH-1:0] ti;
    logic signed [WORD-1:0] x;
    logic signed [WORD-1:0] g;
    logic signed [WORD-1:0] r;
    logic signed [PW-1:0]   p_gr;
    logic signed [SW-1:0]   v_full;
    logic signed [WORD-1:0] v;
    logic signed [WORD-1:0] y;

    assign ti = tau[WORD-1:FRAC];
    assign x  = in;
    assign g  = gain;

    always_comb begin
        d = AW'(1);
        if (ti <= TZERO)
            d = AW'(1);
        else if (ti >= TMAX)
            d = AW'(MAXDELAY - 1);
        else
            d = ti[AW-1:0];
    end

    // Slots not yet written since reset read as silence.
    assign ra = wp - d;
    assign r  = (fill >= {1'b0, d}) ? mem[ra] : '0;

    assign p_gr   = PW'(g) * PW'(r);
    assign v_full = SW'(x) + SW'(p_gr >>> FRAC);
    assign v      = reduce(v_full);

    generate
        if (MODE == 0) begin : g_comb
            assign y = r;
        end else begin : g_allpass
            logic signed [PW-1:0]   p_gi;
            logic signed [PW-1:0]   n_gi;
            logic signed [PW-1:0]   p_gg;
            logic signed [SW-1:0]   a_full;
            logic signed [WORD-1:0] a;
            logic signed [PW-1:0]   p_ar;
            logic signed [SW-1:0]   y_full;

            assign p_gi   = PW'(g) * PW'(x);
            assign n_gi   = -p_gi;
            assign p_gg   = PW'(g) * PW'(g);
            assign a_full = ONE - SW'(p_gg >>> FRAC);
            assign a      = reduce(a_full);
            assign p_ar   = PW'(a) * PW'(r);
            assign y_full = SW'(n_gi >>> FRAC) + SW'(p_ar >>> FRAC);
            assign y      = reduce(y_full);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            wp   <= '0;
            fill <= '0;
        end else if (sample_en) begin
            out <= y;
            wp  <= wp + AW'(1);
            if (fill != FULL)
                fill <= fill + (AW+1)'(1);
        end
    end

    // Delay-line RAM is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (sample_en && !rst)
            mem[wp] <= v;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && sample_en)
            assert (!$isunknown(in)) else $error("schroeder_filter: in is X on strobe");
    end
`endif

endmodule

// File: tb/tb_schroeder_filter.sv
// Directed bench for schroeder_filter: comb and all-pass instances, scoreboard queue.
module tb_schroeder_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic [31:0] in;
    logic [31:0] tau;
    logic [31:0] gain;
    logic [31:0] out_c;
    logic [31:0] out_ap;

    int nassert = 0;
    int nfail   = 0;

    typedef struct packed {
        logic        ap;
        logic [31:0] e;
    } sb_t;

    sb_t sb [$];

    always #5 clk = ~clk;

    schroeder_filter #(.MODE(0)) u_comb (
        .clk(clk), .rst(rst), .sample_en(sample_en),
        .in(in), .tau(tau), .gain(gain), .out(out_c)
    );

    schroeder_filter #(.MODE(1)) u_ap (
        .clk(clk), .rst(rst), .sample_en(sample_en),
        .in(in), .tau(tau), .gain(gain), .out(out_ap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] x, input logic [31:0] e,
                          input logic ap, input string tag);
        sb_t item;
        @(negedge clk);
        in        = x;
        sample_en = 1'b1;
        sb.push_back('{ap: ap, e: e});
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        item = sb.pop_front();
        check(tag, item.ap ? out_ap : out_c, item.e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] comb_exp(input int i);
        case (i)
            4:       return 32'd256;
            8:       return 32'd128;
            12:      return 32'd64;
            16:      return 32'd32;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ap_exp(input int i);
        case (i)
            0:       return 32'hFFFF_FF80;
            2:       return 32'd192;
            4:       return 32'd96;
            6:       return 32'd48;
            default: return 32'd0;
        endcase
    endfunction

    task automatic comb_run(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++)
            strobe((i == 0) ? 32'd256 : 32'd0, comb_exp(i), 1'b0,
                   $sformatf("%s[%0d]", tag, i));
    endtask

    initial begin
        logic [31:0] sat_exp [4];
        rst       = 1'b1;
        sample_en = 1'b0;
        in        = '0;
        tau       = 32'h400;
        gain      = 32'd128;
        repeat (2) @(posedge clk);
        #1;
        check("reset_comb", out_c, 32'd0);
        check("reset_ap", out_ap, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // comb impulse, D=4, g=0.5
        comb_run(0, 19, "comb");

        // all-pass impulse, D=2, g=0.5
        do_reset();
        tau  = 32'h200;
        gain = 32'd128;
        for (int i = 0; i < 8; i++)
            strobe((i == 0) ? 32'd256 : 32'd0, ap_exp(i), 1'b1,
                   $sformatf("ap[%0d]", i));

        // saturation vs wrap, D=1, g=1.0
        do_reset();
        tau  = 32'h100;
        gain = 32'd256;
        sat_exp[0] = 32'h0000_0000;
        sat_exp[1] = 32'h4000_0000;
`ifdef FILTER_SATURATE_EN
        sat_exp[2] = 32'h7FFF_FFFF;
        sat_exp[3] = 32'h7FFF_FFFF;
`else
        sat_exp[2] = 32'h8000_0000;
        sat_exp[3] = 32'hC000_0000;
`endif
        for (int i = 0; i < 4; i++)
            strobe(32'h4000_0000, sat_exp[i], 1'b0, $sformatf("sat[%0d]", i));

        // tau clamp: zero, negative, oversize
        gain = 32'd0;
        do_reset();
        tau = 32'h0;
        strobe(32'd256, 32'd0, 1'b0, "tau0[0]");
        strobe(32'd0, 32'd256, 1'b0, "tau0[1]");
        strobe(32'd0, 32'd0, 1'b0, "tau0[2]");
        do_reset();
        tau = 32'hFFFF_FD00;
        strobe(32'd256, 32'd0, 1'b0, "tauneg[0]");
        strobe(32'd0, 32'd256, 1'b0, "tauneg[1]");
        strobe(32'd0, 32'd0, 1'b0, "tauneg[2]");
        do_reset();
        tau = 32'h7FFF_FF00;
        strobe(32'd256, 32'd0, 1'b0, "taubig[0]");
        for (int i = 1; i < 6; i++)
            strobe(32'd0, 32'd0, 1'b0, $sformatf("taubig[%0d]", i));

        // tau 4 -> 8 mid-stream
        do_reset();
        tau = 32'h400;
        strobe(32'd256, 32'd0, 1'b0, "tauchg[0]");
        strobe(32'd0, 32'd0, 1'b0, "tauchg[1]");
        strobe(32'd0, 32'd0, 1'b0, "tauchg[2]");
        tau = 32'h800;
        for (int i = 3; i < 12; i++)
            strobe(32'd0, (i == 8) ? 32'd256 : 32'd0, 1'b0,
                   $sformatf("tauchg[%0d]", i));

        // async reset between strobes, then full impulse again
        do_reset();
        tau  = 32'h400;
        gain = 32'd128;
        comb_run(0, 4, "pre_rst");
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_comb", out_c, 32'd0);
        check("async_rst_ap", out_ap, 32'd0);
        #1;
        rst = 1'b0;
        comb_run(0, 19, "post_rst");

        // strobe gating: 10 idle clks must not move out or wp
        do_reset();
        comb_run(0, 4, "gate_a");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("gate_hold[%0d]", i), out_c, 32'd256);
        end
        comb_run(5, 17, "gate_b");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
